// File: rtl/popcnt_word_gen.sv
// Streams every WIDTH-bit word with exactly k ones, in ascending order, over
// a valid/ready handshake. Successive words come from the Gosper step.
module popcnt_word_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1),
  parameter int IDXW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    k,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam int            W1      = WIDTH + 1;
  localparam int            TZW     = $clog2(W1);
  localparam logic [CW-1:0] WIDTH_K = CW'(WIDTH);

  state_t        state;
  logic [CW-1:0] k_q;

  // Gosper intermediates carry one extra bit so r = x + c cannot wrap.
  logic [W1-1:0]    x_ext;
  logic [W1-1:0]    c_ext;
  logic [W1-1:0]    r_ext;
  logic [W1-1:0]    spread;
  logic [W1-1:0]    next_ext;
  logic [TZW-1:0]   tz;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] last_word;
  logic [1:0]       unused_msbs;
  logic             fire;

  assign x_ext  = {1'b0, out_data};
  assign c_ext  = x_ext & (~x_ext + 1'b1);
  assign r_ext  = x_ext + c_ext;
  assign spread = (r_ext ^ x_ext) >> 2;

  // Trailing-zero count of the isolated lowest set bit, as a priority encoder.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can
    // leave it unassigned and infer a latch.
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (c_ext[i]) tz = TZW'(i);
    end
  end

  assign next_ext  = r_ext | (spread >> tz);
  assign next_word = next_ext[WIDTH-1:0];

  // The carry bit of r only fires past the final word, which is never stepped.
  assign unused_msbs = {c_ext[WIDTH], next_ext[WIDTH]};

  // Lowest word with k ones: k ones packed at the bottom; the last one packs
  // them at the top.
  assign first_word = {WIDTH{1'b1}} >> (WIDTH_K - k);
  assign last_word  = ~({WIDTH{1'b1}} >> k_q);

  assign fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_q       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here sees the pre-edge values of the others.
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (k > WIDTH_K) begin
              err <= 1'b1;
            end else begin
              state     <= RUN;
              k_q       <= k;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= first_word;
              out_idx   <= '0;
              out_last  <= (k == '0) || (k == WIDTH_K);
            end
          end
        end

        RUN: begin
          if (fire) begin
            if (out_last) begin
              state     <= FLUSH;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_data <= next_word;
              out_idx  <= out_idx + 1'b1;
              out_last <= (next_word == last_word);
            end
          end
        end

        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
